// File: rtl/audio_dac.sv
// audio_dac: serializes stereo PCM pairs MSB-first onto the codec DAC line, clocked by AUD_BCLK.
// Build option AUDIO_DAC_REPEAT_ON_UNDERRUN_EN: on underrun, repeat the last pair instead of sending silence.
module audio_dac #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  AUD_BCLK,
  input  logic                  rst,
  input  logic                  AUD_DACLRCK,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] left_sample,
  input  logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_ready,
  output logic                  AUD_DACDAT,
  output logic                  frame_done,
  output logic                  underrun
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    lrck_q;
  logic                    hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0]   hold_left_q, hold_left_d;
  logic [DATA_WIDTH-1:0]   hold_right_q, hold_right_d;
  logic [DATA_WIDTH-1:0]   active_left_q, active_left_d;
  logic [DATA_WIDTH-1:0]   active_right_q, active_right_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    dat_q, dat_d;
  logic                    frame_done_q, frame_done_d;
  logic                    underrun_q, underrun_d;

  logic rise;
  logic fall;
  logic accept;
  logic right_start;

  assign rise         = AUD_DACLRCK & ~lrck_q;
  assign fall         = ~AUD_DACLRCK & lrck_q;
  assign sample_ready = ~hold_full_q;
  assign accept       = sample_valid & ~hold_full_q;
  // A fall seen before the first left slot is ignored; only a running frame has a right slot.
  assign right_start  = fall & (state_q != IDLE);

  assign AUD_DACDAT = dat_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = LEFT;
      LEFT:    if (rise) state_d = LEFT;  else if (fall) state_d = RIGHT;
      RIGHT:   if (rise) state_d = LEFT;  else if (fall) state_d = RIGHT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_full_d    = hold_full_q;
    hold_left_d    = hold_left_q;
    hold_right_d   = hold_right_q;
    active_left_d  = active_left_q;
    active_right_d = active_right_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    dat_d          = dat_q;
    frame_done_d   = 1'b0;
    underrun_d     = 1'b0;

    if (rise) begin
      if (hold_full_q) begin
        active_left_d  = hold_left_q;
        active_right_d = hold_right_q;
        hold_full_d    = 1'b0;
      end else begin
`ifdef AUDIO_DAC_REPEAT_ON_UNDERRUN_EN
        active_left_d  = active_left_q;
        active_right_d = active_right_q;
`else
        active_left_d  = '0;
        active_right_d = '0;
`endif
        underrun_d = 1'b1;
      end
      shift_d      = active_left_d;
      dat_d        = active_left_d[DATA_WIDTH-1];
      cnt_d        = CNT_ONE;
      frame_done_d = 1'b1;
    end else if (right_start) begin
      shift_d = active_right_q;
      dat_d   = active_right_q[DATA_WIDTH-1];
      cnt_d   = CNT_ONE;
    end else if (state_q == IDLE) begin
      dat_d = 1'b0;
    end else if (cnt_q < CNT_FULL) begin
      shift_d = shift_q << 1;
      dat_d   = shift_q[DATA_WIDTH-2];
      cnt_d   = cnt_q + CNT_ONE;
    end else begin
      dat_d = 1'b0;
    end

    // A pair arriving on a starved left-slot start lands in hold and plays next frame.
    if (accept) begin
      hold_full_d  = 1'b1;
      hold_left_d  = left_sample;
      hold_right_d = right_sample;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge AUD_BCLK) begin
    if (rst) begin
      state_q        <= IDLE;
      lrck_q         <= 1'b0;
      hold_full_q    <= 1'b0;
      active_left_q  <= '0;
      active_right_q <= '0;
      cnt_q          <= '0;
      dat_q          <= 1'b0;
      frame_done_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      lrck_q         <= AUD_DACLRCK;
      hold_full_q    <= hold_full_d;
      active_left_q  <= active_left_d;
      active_right_q <= active_right_d;
      cnt_q          <= cnt_d;
      dat_q          <= dat_d;
      frame_done_q   <= frame_done_d;
      underrun_q     <= underrun_d;
    end
  end

  // NOTE: pure data registers carry no reset; hold_full_q and the slot logic gate every use of them.
  always_ff @(posedge AUD_BCLK) begin
    hold_left_q  <= hold_left_d;
    hold_right_q <= hold_right_d;
    shift_q      <= shift_d;
  end

endmodule

// File: tb/tb_audio_dac.sv
// Scoreboard bench for audio_dac: a 32-bit and a 16-bit instance share LRCK/reset;
// per-cycle expectations are queued by the stimulus and popped by one monitor per instance.
`timescale 1ns/1ps
module tb_audio_dac;

`ifdef AUDIO_DAC_REPEAT_ON_UNDERRUN_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        lrck;
  logic        v32, rdy32, dat32, fd32, ur32;
  logic [31:0] l32, r32;
  logic        v16, rdy16, dat16, fd16, ur16;
  logic [15:0] l16, r16;

  audio_dac #(.DATA_WIDTH(32)) u32 (
    .AUD_BCLK(clk), .rst(rst), .AUD_DACLRCK(lrck),
    .sample_valid(v32), .left_sample(l32), .right_sample(r32),
    .sample_ready(rdy32), .AUD_DACDAT(dat32), .frame_done(fd32), .underrun(ur32)
  );

  audio_dac #(.DATA_WIDTH(16)) u16 (
    .AUD_BCLK(clk), .rst(rst), .AUD_DACLRCK(lrck),
    .sample_valid(v16), .left_sample(l16), .right_sample(r16),
    .sample_ready(rdy16), .AUD_DACDAT(dat16), .frame_done(fd16), .underrun(ur16)
  );

  typedef struct {
    int   tag;
    logic dat;
    logic fd;
    logic ur;
    logic rc;
    logic rdy;
  } exp_t;

  typedef struct { logic [31:0] l; logic [31:0] r; } p32_t;
  typedef struct { logic [15:0] l; logic [15:0] r; } p16_t;

  exp_t sb32[$];
  exp_t sb16[$];
  p32_t pq32[$];
  p16_t pq16[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int tag, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%b expected=%b", name, tag, act, exp);
  endtask

  function automatic exp_t mk(input logic dat, input logic fd, input logic ur,
                              input logic rc, input logic rdy);
    exp_t e;
    e.tag = 0; e.dat = dat; e.fd = fd; e.ur = ur; e.rc = rc; e.rdy = rdy;
    return e;
  endfunction

  // Monitors: outputs are sampled on the falling edge, after the posedge they belong to.
  initial begin : mon32
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb32.size() > 0 && sb32[0].tag <= cyc) begin
        e = sb32.pop_front();
        check("u32 dacdat", e.tag, dat32, e.dat);
        check("u32 frame_done", e.tag, fd32, e.fd);
        check("u32 underrun", e.tag, ur32, e.ur);
        if (e.rc) check("u32 sample_ready", e.tag, rdy32, e.rdy);
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb16.size() > 0 && sb16[0].tag <= cyc) begin
        e = sb16.pop_front();
        check("u16 dacdat", e.tag, dat16, e.dat);
        check("u16 frame_done", e.tag, fd16, e.fd);
        check("u16 underrun", e.tag, ur16, e.ur);
        if (e.rc) check("u16 sample_ready", e.tag, rdy16, e.rdy);
      end
    end
  end

  // Upstream producers: present the queue head, pop it once the handshake completes.
  initial begin : prod32
    logic acc;
    v32 = 1'b0; l32 = '0; r32 = '0;
    forever begin
      @(negedge clk);
      if (pq32.size() > 0) begin
        v32 = 1'b1; l32 = pq32[0].l; r32 = pq32[0].r;
      end else begin
        v32 = 1'b0;
      end
      acc = v32 && rdy32;
      @(posedge clk);
      if (acc && !rst) pq32.delete(0);
    end
  end

  initial begin : prod16
    logic acc;
    v16 = 1'b0; l16 = '0; r16 = '0;
    forever begin
      @(negedge clk);
      if (pq16.size() > 0) begin
        v16 = 1'b1; l16 = pq16[0].l; r16 = pq16[0].r;
      end else begin
        v16 = 1'b0;
      end
      acc = v16 && rdy16;
      @(posedge clk);
      if (acc && !rst) pq16.delete(0);
    end
  end

  task automatic enq(input logic [31:0] a_l, input logic [31:0] a_r,
                     input logic [15:0] b_l, input logic [15:0] b_r);
    p32_t p; p16_t q;
    p.l = a_l; p.r = a_r; q.l = b_l; q.r = b_r;
    pq32.push_back(p);
    pq16.push_back(q);
  endtask

  // Enqueue at a posedge so the pair is first offered together with the next driven cycle.
  task automatic push(input logic [31:0] a_l, input logic [31:0] a_r,
                      input logic [15:0] b_l, input logic [15:0] b_r);
    @(posedge clk);
    enq(a_l, a_r, b_l, b_r);
  endtask

  task automatic drive(input logic lr, input logic r, input exp_t e32, input exp_t e16);
    @(negedge clk);
    lrck = lr;
    rst  = r;
    e32.tag = cyc + 1;
    e16.tag = cyc + 1;
    sb32.push_back(e32);
    sb16.push_back(e16);
  endtask

  task automatic idle(input int n, input logic rc, input logic rdy);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, rc, rdy), mk(1'b0, 1'b0, 1'b0, rc, rdy));
  endtask

  // One frame: hi cycles of LRCK high, lo cycles low; expected bits come from the given words.
  task automatic frame(input int hi, input int lo,
                       input logic [31:0] el32, input logic [31:0] er32,
                       input logic [15:0] el16, input logic [15:0] er16,
                       input logic ur, input logic r0, input logic r1);
    for (int i = 0; i < hi + lo; i++) begin
      logic lr;
      int   j;
      logic b32;
      logic b16;
      logic rdy;
      lr  = (i < hi);
      j   = lr ? i : i - hi;
      b32 = 1'b0;
      b16 = 1'b0;
      if (j < 32) b32 = lr ? el32[31-j] : er32[31-j];
      if (j < 16) b16 = lr ? el16[15-j] : er16[15-j];
      rdy = (i == 0) ? r0 : r1;
      drive(lr, 1'b0,
            mk(b32, i == 0, ur && (i == 0), i < 2, rdy),
            mk(b16, i == 0, ur && (i == 0), i < 2, rdy));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "simulation did not finish");
  end

  initial begin : stim
    rst  = 1'b1;
    lrck = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1), mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle(2, 1'b1, 1'b1);

    // Basic stereo frame with a pair buffered ahead of the first rise.
    push(32'h8000_0001, 32'h7FFF_FFFE, 16'hA5A5, 16'h5A5A);
    idle(4, 1'b1, 1'b0);
    frame(32, 32, 32'h8000_0001, 32'h7FFF_FFFE, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1'b1);

    // Nothing supplied: underrun (silence, or repeat when the option is built in).
    frame(32, 32, REP ? 32'h8000_0001 : 32'h0, REP ? 32'h7FFF_FFFE : 32'h0,
          REP ? 16'hA5A5 : 16'h0, REP ? 16'h5A5A : 16'h0, 1'b1, 1'b1, 1'b1);

    // Pair A buffered, pair B held on the handshake until the slot start frees the buffer.
    push(32'hDEAD_BEEF, 32'h1234_5678, 16'h1357, 16'hFFFF);
    enq(32'hCAFE_F00D, 32'h0F0F_F0F0, 16'h8001, 16'h7FFE);
    idle(4, 1'b1, 1'b0);
    frame(32, 32, 32'hDEAD_BEEF, 32'h1234_5678, 16'h1357, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    frame(32, 32, 32'hCAFE_F00D, 32'h0F0F_F0F0, 16'h8001, 16'h7FFE, 1'b0, 1'b1, 1'b1);

    // Short left slot of 10 BCLK.
    push(32'hF0F0_AAAA, 32'h8888_1111, 16'hC3C3, 16'h3C3C);
    idle(4, 1'b1, 1'b0);
    frame(10, 32, 32'hF0F0_AAAA, 32'h8888_1111, 16'hC3C3, 16'h3C3C, 1'b0, 1'b1, 1'b1);

    // Pair offered exactly on the left-slot start with the buffer empty.
    push(32'h0123_4567, 32'h89AB_CDEF, 16'h0F1E, 16'hE1F0);
    frame(32, 32, REP ? 32'hF0F0_AAAA : 32'h0, REP ? 32'h8888_1111 : 32'h0,
          REP ? 16'hC3C3 : 16'h0, REP ? 16'h3C3C : 16'h0, 1'b1, 1'b0, 1'b0);
    frame(32, 32, 32'h0123_4567, 32'h89AB_CDEF, 16'h0F1E, 16'hE1F0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a right slot while a pair is held.
    push(32'hA0A0_0505, 32'h5050_0A0A, 16'hB4B4, 16'h4B4B);
    enq(32'hFFFF_0000, 32'h0000_FFFF, 16'hFF00, 16'h00FF);
    idle(4, 1'b1, 1'b0);
    frame(32, 10, 32'hA0A0_0505, 32'h5050_0A0A, 16'hB4B4, 16'h4B4B, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1), mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    idle(4, 1'b1, 1'b1);
    frame(32, 32, 32'h0, 32'h0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("u32 scoreboard drained", cyc, sb32.size() == 0, 1'b1);
    check("u16 scoreboard drained", cyc, sb16.size() == 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
